// File: rtl/ctrl_channel.sv
// rtl/ctrl_channel.sv - enable/mode control source with registered forwarding to a leaf consumer
module ctrl_channel #(
    parameter int                MODE_W     = 4,
    parameter int                FWD_STAGES = 2,
    parameter logic [MODE_W-1:0] MODE_RST   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     set_valid,
    input  logic                     set_enable,
    input  logic [MODE_W-1:0]        set_mode,
    output logic                     ctrl_enable,
    output logic [MODE_W-1:0]        ctrl_mode,
    output logic                     leaf_enable,
    output logic [MODE_W-1:0]        leaf_mode,
    output logic [(2**MODE_W)-1:0]   mode_onehot,
    output logic                     cfg_changed
);

    logic              ctrl_enable_q, ctrl_enable_d;
    logic [MODE_W-1:0] ctrl_mode_q, ctrl_mode_d;
    logic              cfg_changed_q, cfg_changed_d;

    always_comb begin
        ctrl_enable_d = ctrl_enable_q;
        ctrl_mode_d   = ctrl_mode_q;
        cfg_changed_d = 1'b0;
        if (set_valid) begin
            ctrl_enable_d = set_enable;
            ctrl_mode_d   = set_mode;
            // Pulse only on a real change; rewriting the same pair is silent.
            cfg_changed_d = ({set_enable, set_mode} != {ctrl_enable_q, ctrl_mode_q});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_enable_q <= 1'b0;
            ctrl_mode_q   <= MODE_RST;
            cfg_changed_q <= 1'b0;
        end else begin
            ctrl_enable_q <= ctrl_enable_d;
            ctrl_mode_q   <= ctrl_mode_d;
            cfg_changed_q <= cfg_changed_d;
        end
    end

    assign ctrl_enable = ctrl_enable_q;
    assign ctrl_mode   = ctrl_mode_q;
    assign cfg_changed = cfg_changed_q;

    generate
        if (FWD_STAGES == 0) begin : g_direct
            assign leaf_enable = ctrl_enable_q;
            assign leaf_mode   = ctrl_mode_q;
        end else begin : g_pipe
            // Enable and mode share one word per hop so the leaf never sees a torn pair.
            logic [MODE_W:0] pipe_q [FWD_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < FWD_STAGES; i++) begin
                        pipe_q[i] <= {1'b0, MODE_RST};
                    end
                end else begin
                    pipe_q[0] <= {ctrl_enable_q, ctrl_mode_q};
                    for (int i = 1; i < FWD_STAGES; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign leaf_enable = pipe_q[FWD_STAGES-1][MODE_W];
            assign leaf_mode   = pipe_q[FWD_STAGES-1][MODE_W-1:0];
        end
    endgenerate

    always_comb begin
        mode_onehot = '0;
        if (leaf_enable) begin
            mode_onehot[leaf_mode] = 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_channel.sv
// tb/tb_ctrl_channel.sv - directed self-checking bench for ctrl_channel
module tb_ctrl_channel;

    logic        clk;
    logic        rst_n;
    logic        set_valid;
    logic        set_enable;
    logic [3:0]  set_mode;
    logic        ctrl_enable;
    logic [3:0]  ctrl_mode;
    logic        leaf_enable;
    logic [3:0]  leaf_mode;
    logic [15:0] mode_onehot;
    logic        cfg_changed;

    int n_checks = 0;
    int n_pass   = 0;

    ctrl_channel #(.MODE_W(4), .FWD_STAGES(2), .MODE_RST(4'b0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_valid  (set_valid),
        .set_enable (set_enable),
        .set_mode   (set_mode),
        .ctrl_enable(ctrl_enable),
        .ctrl_mode  (ctrl_mode),
        .leaf_enable(leaf_enable),
        .leaf_mode  (leaf_mode),
        .mode_onehot(mode_onehot),
        .cfg_changed(cfg_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic en, input logic [3:0] mode);
        set_valid  = 1'b1;
        set_enable = en;
        set_mode   = mode;
        step();
        set_valid  = 1'b0;
    endtask

    task automatic check_leaf(input string tag, input logic en, input logic [3:0] mode,
                              input logic [15:0] onehot);
        check({tag, "_leaf_en"},  {31'd0, leaf_enable}, {31'd0, en});
        check({tag, "_leaf_mode"}, {28'd0, leaf_mode},  {28'd0, mode});
        check({tag, "_onehot"},   {16'd0, mode_onehot}, {16'd0, onehot});
    endtask

    logic [3:0]  exp_ctrl_mode [6];
    logic        exp_cfg       [6];
    logic        exp_leaf_en   [6];
    logic [3:0]  exp_leaf_mode [6];
    logic [15:0] exp_onehot    [6];

    initial begin
        rst_n = 1'b0; set_valid = 1'b0; set_enable = 1'b0; set_mode = 4'h0;

        // 1: reset holds everything low even with writes offered
        for (int i = 0; i < 4; i++) begin
            set_valid = ~set_valid; set_enable = 1'b1; set_mode = 4'(i + 3);
            step();
            check("rst_ctrl_en", {31'd0, ctrl_enable}, 32'd0);
            check("rst_ctrl_mode", {28'd0, ctrl_mode}, 32'd0);
            check("rst_cfg", {31'd0, cfg_changed}, 32'd0);
            check_leaf("rst", 1'b0, 4'h0, 16'h0000);
        end
        set_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check_leaf("post_rst", 1'b0, 4'h0, 16'h0000);

        // 2: first write, 1-cycle source latency, 3-cycle leaf latency
        write(1'b1, 4'h1);
        check("w1_ctrl_en", {31'd0, ctrl_enable}, 32'd1);
        check("w1_ctrl_mode", {28'd0, ctrl_mode}, 32'd1);
        check("w1_cfg", {31'd0, cfg_changed}, 32'd1);
        check_leaf("w1_c1", 1'b0, 4'h0, 16'h0000);
        step();
        check("w1_cfg_once", {31'd0, cfg_changed}, 32'd0);
        check_leaf("w1_c2", 1'b0, 4'h0, 16'h0000);
        step();
        check_leaf("w1_c3", 1'b1, 4'h1, 16'h0002);
        check("w1_cfg_idle", {31'd0, cfg_changed}, 32'd0);

        // 3: identical rewrite produces no pulse
        write(1'b1, 4'h1);
        check("same_cfg", {31'd0, cfg_changed}, 32'd0);
        check("same_ctrl_mode", {28'd0, ctrl_mode}, 32'd1);
        step(); step();
        check_leaf("same", 1'b1, 4'h1, 16'h0002);

        // 4: disabled mode F, onehot gated off
        write(1'b0, 4'hF);
        check("w4_cfg", {31'd0, cfg_changed}, 32'd1);
        check("w4_ctrl_en", {31'd0, ctrl_enable}, 32'd0);
        check("w4_ctrl_mode", {28'd0, ctrl_mode}, 32'hF);
        step();
        check_leaf("w4_c2", 1'b1, 4'h1, 16'h0002);
        step();
        check_leaf("w4_c3", 1'b0, 4'hF, 16'h0000);

        // 5: back-to-back writes 1,2,3 pipeline without coalescing
        exp_ctrl_mode = '{4'h1, 4'h2, 4'h3, 4'h3, 4'h3, 4'h3};
        exp_cfg       = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_leaf_en   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_leaf_mode = '{4'hF, 4'hF, 4'h1, 4'h2, 4'h3, 4'h3};
        exp_onehot    = '{16'h0000, 16'h0000, 16'h0002, 16'h0004, 16'h0008, 16'h0008};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) write(1'b1, 4'(i + 1));
            else step();
            check($sformatf("b2b%0d_ctrl_mode", i), {28'd0, ctrl_mode}, {28'd0, exp_ctrl_mode[i]});
            check($sformatf("b2b%0d_cfg", i), {31'd0, cfg_changed}, {31'd0, exp_cfg[i]});
            check_leaf($sformatf("b2b%0d", i), exp_leaf_en[i], exp_leaf_mode[i], exp_onehot[i]);
        end

        // 6: asynchronous reset with writes in flight
        write(1'b1, 4'h5);
        write(1'b1, 4'h6);
        set_valid = 1'b1; set_enable = 1'b1; set_mode = 4'h9;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl_en", {31'd0, ctrl_enable}, 32'd0);
        check("arst_ctrl_mode", {28'd0, ctrl_mode}, 32'd0);
        check("arst_cfg", {31'd0, cfg_changed}, 32'd0);
        check_leaf("arst", 1'b0, 4'h0, 16'h0000);
        step(); step();
        check_leaf("arst_hold", 1'b0, 4'h0, 16'h0000);
        set_valid = 1'b0;
        rst_n = 1'b1;
        step();
        write(1'b1, 4'h7);
        check("pr_ctrl_mode", {28'd0, ctrl_mode}, 32'h7);
        check("pr_cfg", {31'd0, cfg_changed}, 32'd1);
        check_leaf("pr_c1", 1'b0, 4'h0, 16'h0000);
        step();
        check_leaf("pr_c2", 1'b0, 4'h0, 16'h0000);
        step();
        check_leaf("pr_c3", 1'b1, 4'h7, 16'h0080);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
